// File: rtl/bicubic_frame_sched.sv
// Frame scheduler: admits WIDTH x HEIGHT pixels into the bicubic core, adds sof/eol/eof and inter-line gaps.
// Optional backpressure counter enabled by defining BICUBIC_SCHED_STALL_CNT_EN.
module bicubic_frame_sched #(
    parameter int DATA_W   = 24,
    parameter int WIDTH    = 960,
    parameter int HEIGHT   = 540,
    parameter int LINE_GAP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof,
    output logic              busy,
    output logic              done,
    output logic [31:0]       stall_cnt
);

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int GW = (LINE_GAP > 0) ? $clog2(LINE_GAP + 1) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [GW-1:0] G_LAST = GW'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state_q;
    logic [XW-1:0] x_cnt_q;
    logic [YW-1:0] y_cnt_q;
    logic [GW-1:0] gap_cnt_q;

    // Handshake valid/ready: a pixel moves only when m_valid and m_ready are both high
    // in the same cycle; abort suppresses both sides so nothing moves in that cycle.
    logic stream_on;
    logic hs;

    assign stream_on = (state_q == STREAM) & ~abort;
    assign m_valid   = stream_on & s_valid;
    assign s_ready   = stream_on & m_ready;
    assign m_data    = s_data;
    assign hs        = m_valid & m_ready;

    assign m_sof = m_valid & (x_cnt_q == '0) & (y_cnt_q == '0);
    assign m_eol = m_valid & (x_cnt_q == X_LAST);
    assign m_eof = m_eol & (y_cnt_q == Y_LAST);
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            x_cnt_q   <= '0;
            y_cnt_q   <= '0;
            gap_cnt_q <= '0;
        end else if (abort) begin
            state_q   <= IDLE;
            x_cnt_q   <= '0;
            y_cnt_q   <= '0;
            gap_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= STREAM;
                        x_cnt_q <= '0;
                        y_cnt_q <= '0;
                    end
                end
                STREAM: begin
                    if (hs) begin
                        if (x_cnt_q == X_LAST) begin
                            x_cnt_q <= '0;
                            if (y_cnt_q == Y_LAST) begin
                                y_cnt_q <= '0;
                                state_q <= DONE;
                            end else begin
                                y_cnt_q <= y_cnt_q + 1'b1;
                                state_q <= (LINE_GAP > 0) ? GAP : STREAM;
                            end
                        end else begin
                            x_cnt_q <= x_cnt_q + 1'b1;
                        end
                    end
                end
                GAP: begin
                    // Gap lasts LINE_GAP cycles so the core can drain its line buffers.
                    if (gap_cnt_q == G_LAST) begin
                        gap_cnt_q <= '0;
                        state_q   <= STREAM;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef BICUBIC_SCHED_STALL_CNT_EN
    logic [31:0] stall_q;

    // Held outside STREAM so software can read the count after the frame completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if ((state_q == IDLE) && start && !abort) begin
            stall_q <= '0;
        end else if ((state_q == STREAM) && s_valid && !m_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_bicubic_frame_sched.sv
// Directed bench for bicubic_frame_sched: scoreboarded frames on a gapped instance and a zero-gap instance.
module tb_bicubic_frame_sched;

    localparam int DATA_W = 24;
    localparam int W      = 4;
    localparam int H      = 3;
    localparam int GAPN   = 2;
    localparam int EW     = DATA_W + 3;

    logic clk = 1'b0;
    logic rst_n;

    logic              start, abort, s_valid, m_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_ready, m_valid, m_sof, m_eol, m_eof, busy, done;
    logic [DATA_W-1:0] m_data;
    logic [31:0]       stall_cnt;

    logic              z_start, z_abort, z_s_valid, z_m_ready;
    logic [DATA_W-1:0] z_s_data;
    logic              z_s_ready, z_m_valid, z_m_sof, z_m_eol, z_m_eof, z_busy, z_done;
    logic [DATA_W-1:0] z_m_data;
    logic [31:0]       z_stall_cnt;

    // {sof, eol, eof, data}
    logic [EW-1:0] exp_q[$];

    int tests = 0;
    int fails = 0;
    int stall_exp = 0;

    always #5 clk = ~clk;

    bicubic_frame_sched #(.DATA_W(DATA_W), .WIDTH(W), .HEIGHT(H), .LINE_GAP(GAPN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
        .busy(busy), .done(done), .stall_cnt(stall_cnt)
    );

    bicubic_frame_sched #(.DATA_W(DATA_W), .WIDTH(W), .HEIGHT(H), .LINE_GAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(z_start), .abort(z_abort),
        .s_valid(z_s_valid), .s_data(z_s_data), .s_ready(z_s_ready),
        .m_valid(z_m_valid), .m_data(z_m_data), .m_ready(z_m_ready),
        .m_sof(z_m_sof), .m_eol(z_m_eol), .m_eof(z_m_eof),
        .busy(z_busy), .done(z_done), .stall_cnt(z_stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_frame();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < W * H; i++) begin
            d = DATA_W'($urandom_range(0, 32'h00FF_FFFF));
            exp_q.push_back({(i == 0), ((i % W) == W - 1), (i == W * H - 1), d});
        end
    endtask

    task automatic chk_stall(input string tag);
`ifdef BICUBIC_SCHED_STALL_CNT_EN
        chk(tag, stall_cnt, stall_exp);
`else
        chk(tag, stall_cnt, 0);
`endif
    endtask

    // mode 0: always flowing, 1: m_ready toggles, 2: upstream starves 5 cycles mid-line
    task automatic run_frame(input int mode, input int abort_at, input bit start_mid);
        int idx = 0;
        int gap_left = 0;
        int starve_left = 0;
        int cyc = 0;
        bit starved = 0;
        bit aborted = 0;
        bit sv, mr;
        logic [EW-1:0] e;
        stall_exp = 0;
        push_frame();
        @(posedge clk); #1;
        start = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        while (idx < W * H && cyc < 200 && !aborted) begin
            sv = 1'b1;
            mr = 1'b1;
            if (mode == 1) mr = ((cyc % 2) == 0);
            if (mode == 2 && idx == 2 && !starved) begin
                starve_left = 5;
                starved = 1'b1;
            end
            if (starve_left > 0) begin
                sv = 1'b0;
                starve_left--;
            end
            s_valid = sv;
            m_ready = mr;
            s_data  = (exp_q.size() > 0) ? exp_q[0][DATA_W-1:0] : '0;
            start   = start_mid && (cyc == 3);
            abort   = (idx == abort_at) && (gap_left == 0);
            @(negedge clk);
            if (abort) begin
                chk("abort_m_valid", m_valid, 0);
                chk("abort_s_ready", s_ready, 0);
                aborted = 1'b1;
            end else if (gap_left > 0) begin
                chk("gap_m_valid", m_valid, 0);
                chk("gap_s_ready", s_ready, 0);
                chk("gap_sideband", {m_sof, m_eol, m_eof}, 0);
                gap_left--;
            end else begin
                chk("m_valid", m_valid, sv);
                chk("s_ready", s_ready, mr);
                if (!sv) chk("idle_sideband", {m_sof, m_eol, m_eof}, 0);
                if (sv && !mr) stall_exp++;
                if (sv && mr) begin
                    e = exp_q.pop_front();
                    chk("m_data", m_data, e[DATA_W-1:0]);
                    chk("sideband", {m_sof, m_eol, m_eof}, e[EW-1:DATA_W]);
                    if (e[DATA_W+1] && !e[DATA_W]) gap_left = GAPN;
                    idx++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; abort = 1'b0; s_valid = 1'b0;
        if (abort_at >= 0) begin
            @(negedge clk);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("abort_no_done", done, 0);
            end
            exp_q.delete();
        end else begin
            chk("frame_len", idx, W * H);
            @(negedge clk);
            chk("done_pulse", done, 1);
            chk("done_busy", busy, 1);
            chk("done_m_valid", m_valid, 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("done_clear", done, 0);
            chk("busy_clear", busy, 0);
            chk_stall("stall_cnt");
        end
    endtask

    initial begin
        logic [EW-1:0] e;
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; s_valid = 1'b1; m_ready = 1'b1; s_data = '0;
        z_start = 1'b0; z_abort = 1'b0; z_s_valid = 1'b0; z_m_ready = 1'b0; z_s_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_sideband", {m_sof, m_eol, m_eof}, 0);
        chk("rst_stall", stall_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_m_valid", m_valid, 0);
        s_valid = 1'b0;

        run_frame(0, -1, 1'b0);
        run_frame(1, -1, 1'b0);
        run_frame(2, -1, 1'b0);
        run_frame(0, 6, 1'b0);
        run_frame(0, -1, 1'b1);

        // start together with abort in IDLE must not launch a frame
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        chk("start_abort_busy", busy, 0);
        chk("start_abort_m_valid", m_valid, 0);
        s_valid = 1'b0;

        // zero-gap instance: back-to-back transfers across line boundaries
        push_frame();
        @(posedge clk); #1;
        z_start = 1'b1;
        @(posedge clk); #1;
        z_start = 1'b0;
        for (int i = 0; i < W * H; i++) begin
            z_s_valid = 1'b1;
            z_m_ready = 1'b1;
            z_s_data  = exp_q[0][DATA_W-1:0];
            @(negedge clk);
            chk("z_m_valid", z_m_valid, 1);
            e = exp_q.pop_front();
            chk("z_m_data", z_m_data, e[DATA_W-1:0]);
            chk("z_sideband", {z_m_sof, z_m_eol, z_m_eof}, e[EW-1:DATA_W]);
            @(posedge clk); #1;
        end
        z_s_valid = 1'b0;
        @(negedge clk);
        chk("z_done", z_done, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("z_busy_clear", z_busy, 0);
        chk("z_stall", z_stall_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bicubic_frame_sched.md
Name: bicubic_frame_sched

Overview:
- Frame scheduler between the source-pixel stream (BMP reader in sim, pixel DMA in silicon) and the bicubic upscaler core.
- On a start command it admits exactly WIDTH x HEIGHT pixels through a zero-latency valid/ready gate.
- Tags each pixel with sof/eol/eof sideband.
- Inserts a programmable blanking gap after each line so the core can flush its line buffers.
- Reports busy/done and supports abort.

Parameters:
- DATA_W, 24, pixel width {R,G,B}.
- WIDTH, 960, source pixels per line.
- HEIGHT, 540, source lines per frame.
- LINE_GAP, 4, idle cycles inserted after every line except the last; 0 means no gap.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- start  in  1  single-cycle frame start request.
- abort  in  1  synchronous frame cancel.
- s_valid  in  1  upstream pixel valid.
- s_data  in  DATA_W  upstream pixel.
- s_ready  out  1  upstream ready.
- m_valid  out  1  pixel valid to core.
- m_data  out  DATA_W  pixel to core.
- m_ready  in  1  core ready.
- m_sof  out  1  current m_data is pixel (0,0).
- m_eol  out  1  current m_data is last of line.
- m_eof  out  1  current m_data is last of frame.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at frame completion.
- stall_cnt  out  32  backpressure cycle count (see Optional Feature).

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: state IDLE, x_cnt=0, y_cnt=0, gap_cnt=0, done=0, stall_cnt=0. s_ready, m_valid, m_sof, m_eol, m_eof and busy are all 0.
- Counters: x_cnt is clog2(WIDTH) bits, y_cnt is clog2(HEIGHT) bits, gap_cnt is clog2(LINE_GAP+1) bits.
- FSM states: IDLE, STREAM, GAP, DONE.
- IDLE:
  - s_ready=0, m_valid=0.
  - start=1 and abort=0 -> STREAM, x_cnt=y_cnt=0.
  - start is ignored in every other state.
- STREAM:
  - Combinational pass-through: m_valid=s_valid, s_ready=m_ready, m_data=s_data. Zero latency, no storage.
  - hs = s_valid & m_ready.
  - On hs with x_cnt<WIDTH-1: x_cnt+1.
  - On hs with x_cnt==WIDTH-1: x_cnt->0.
    - If y_cnt==HEIGHT-1 -> DONE.
    - Else y_cnt+1, and -> GAP if LINE_GAP>0, otherwise stay in STREAM.
- GAP:
  - m_valid=0, s_ready=0.
  - gap_cnt counts 0..LINE_GAP-1, then -> STREAM with gap_cnt cleared.
- DONE:
  - done=1 for exactly this one cycle; m_valid=0, s_ready=0.
  - -> IDLE next cycle.
- Sideband (combinational, qualified by m_valid):
  - m_sof = (x_cnt==0 & y_cnt==0).
  - m_eol = (x_cnt==WIDTH-1).
  - m_eof = m_eol & (y_cnt==HEIGHT-1).
- data_hold: m_data changes only as upstream changes it; the block never reorders or drops pixels.
- abort:
  - In the abort cycle, m_valid and s_ready are forced to 0, so no transfer occurs.
  - Next state is IDLE and counters clear; no done pulse.
  - Abort wins over start and over an end-of-frame transition in the same cycle.
- Reset mid-frame: immediate return to reset values; the upstream pointer is not restored.
- Degenerate size WIDTH=1: every pixel asserts m_eol, and a gap follows every pixel.

Optional Feature:
- Macro: BICUBIC_SCHED_STALL_CNT_EN.
- Defined:
  - stall_cnt increments every STREAM cycle with s_valid=1 and m_ready=0.
  - Saturates at 32'hFFFF_FFFF.
  - Clears on an accepted start; holds its value in IDLE/DONE so software can read it after the frame.
- Undefined: stall_cnt is tied to 32'd0 and the counter logic is not synthesised.

Test Plan (WIDTH=4, HEIGHT=3, LINE_GAP=2 unless stated):
- Full frame, s_valid=1, m_ready=1:
  - 12 handshakes, m_sof only on the first, m_eol on handshakes 4/8/12, m_eof only on the 12th.
  - Exactly 2 idle cycles after handshakes 4 and 8.
  - done pulses once, 1 cycle after the 12th handshake; busy then drops.
- m_ready toggled 1,0,1,0 with s_valid=1:
  - Transfers only on m_ready=1 cycles; pixel order preserved, x_cnt holds while stalled.
  - With macro, stall_cnt equals the number of m_ready=0 STREAM cycles.
- Upstream starvation (s_valid=0 for 5 cycles mid-line): m_valid=0, x_cnt holds, no sideband glitch; stall_cnt unchanged.
- Abort at pixel (2,1) concurrent with s_valid=m_ready=1:
  - No transfer that cycle, IDLE next, busy=0, no done pulse.
  - A new start restarts at (0,0) with m_sof=1.
- start while busy is ignored. start+abort in IDLE stays IDLE.
- LINE_GAP=0: 12 back-to-back transfers with no bubbles across line boundaries; done after the last.
